ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port i_stall, input, 1, decode stall from pipeline control; holds the decode-side outputs.
REQ-005 SHALL have port i_redirect, input, 1, taken branch/jump from execute.
REQ-006 SHALL have port i_redirect_pc, input, 16, the redirect target, valid only while i_redirect=1.
REQ-007 SHALL have port o_imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port o_imem_addr, output, 16, word address of the request.
REQ-009 SHALL have port i_imem_ack, input, 1, memory response strobe.
REQ-010 SHALL have port i_imem_rdata, input, 16, instruction word, valid only while i_imem_ack=1.
REQ-011 SHALL have port o_ir_id, output, 16, instruction word to decode.
REQ-012 SHALL have port o_pc_id, output, 16, address of o_ir_id.
REQ-013 SHALL have port o_ir_valid, output, 1, o_ir_id holds a real instruction; 0 means NOP.

Function
REQ-014 SHALL run a three-state FSM: FETCH (req=1), HOLD (req=0, one word buffered), FLUSH (req=1, returning data discarded).
REQ-015 SHALL keep o_imem_addr stable while o_imem_req=1 until the cycle i_imem_ack=1; ack may arrive in the request cycle (zero wait) or later.
REQ-016 In FETCH, ack with i_stall=0 SHALL load o_ir_id<=rdata, o_pc_id<=addr, o_ir_valid<=1 and advance the fetch PC by 1 (16-bit wrap FFFF->0000), sustaining 1 instruction/cycle at zero wait.
REQ-017 In FETCH, cycles without ack and i_stall=0 SHALL set o_ir_valid<=0 and o_ir_id<=16'h0000 (bubble).
REQ-018 While i_stall=1, o_ir_id, o_pc_id and o_ir_valid SHALL hold their values.
REQ-019 In FETCH, ack with i_stall=1 SHALL store rdata/addr in the one-entry buffer, advance the PC and enter HOLD.
REQ-020 In HOLD, the first cycle with i_stall=0 SHALL move the buffer into o_ir_id/o_pc_id with o_ir_valid<=1 and return to FETCH.
REQ-021 i_redirect=1 SHALL take priority over i_stall and any ack: next cycle o_ir_valid=0, o_ir_id=16'h0000, fetch PC=i_redirect_pc, and the buffer is emptied.
REQ-022 On redirect in FETCH without same-cycle ack, SHALL enter FLUSH keeping the old address until ack, discard that word, then enter FETCH at the target.
REQ-023 On redirect in FETCH with same-cycle ack, or in HOLD, SHALL discard the word and enter FETCH at the target directly.
REQ-024 A second redirect during FLUSH SHALL replace the pending target; last one wins.

Reset
REQ-025 rst=1 at a clock edge SHALL set state=FETCH, fetch PC=RESET_PC, o_ir_id=16'h0000, o_pc_id=16'h0000, o_ir_valid=0, buffer empty, and counter (if present) = 0.
REQ-026 While rst=1 SHALL drive o_imem_req=0; an ack arriving during reset SHALL be ignored, and reset mid-request abandons it.
REQ-027 First request (addr=RESET_PC) SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-028 With macro IFETCH_STALL_CNT_EN defined, SHALL add output o_stall_cnt[15:0], counting cycles where i_stall=1 and o_ir_valid=1, saturating at 16'hFFFF, cleared only by rst.
REQ-029 Without IFETCH_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-030 Zero-wait memory returning rdata=addr^16'hA5A5, no stall: o_pc_id 0,1,2,3 on consecutive cycles, o_ir_id=A5A5,A5A4,A5A7,A5A6.
REQ-031 2-cycle-latency ack: every request yields one valid instruction followed by one bubble (o_ir_valid=0, o_ir_id=0000); o_imem_addr stable across the wait.
REQ-032 i_stall=1 for 3 cycles with ack landing in the 1st: outputs frozen, HOLD entered, req low; on release buffered word appears next cycle, then fetch resumes at next PC.
REQ-033 Redirect to 16'h0040 while a 3-cycle request to 16'h0005 is outstanding: FLUSH, its data never becomes valid, next request addr=0040, o_pc_id=0040 with valid=1.
REQ-034 rst pulsed mid-request with ack in same cycle: outputs zero, no valid instruction, first post-reset addr=RESET_PC; with IFETCH_STALL_CNT_EN, 5 held-valid stall cycles give o_stall_cnt=5.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: pipeline-control, instruction-memory and decode-side signals of ifetch_unit.
// o_stall_cnt exists only when IFETCH_STALL_CNT_EN is defined.
interface ifetch_unit_if;
  logic i_stall;
  logic i_redirect;
  logic [15:0] i_redirect_pc;
  logic o_imem_req;
  logic [15:0] o_imem_addr;
  logic i_imem_ack;
  logic [15:0] i_imem_rdata;
  logic [15:0] o_ir_id;
  logic [15:0] o_pc_id;
  logic o_ir_valid;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] o_stall_cnt;
`endif
  modport master (
    input i_stall, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata,
`ifdef IFETCH_STALL_CNT_EN
    output o_stall_cnt,
`endif
    output o_imem_req, o_imem_addr, o_ir_id, o_pc_id, o_ir_valid
  );
  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata,
`ifdef IFETCH_STALL_CNT_EN
    input o_stall_cnt,
`endif
    input o_imem_req, o_imem_addr, o_ir_id, o_pc_id, o_ir_valid
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch with one-entry stall buffer and redirect flush.
// Define IFETCH_STALL_CNT_EN to add the saturating o_stall_cnt counter.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic clk,
  input logic rst,
  ifetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;
  state_t state, state_n;
  logic [15:0] pc, pc_n, tgt, tgt_n, buf_ir, buf_ir_n, buf_pc, buf_pc_n;
  logic [15:0] ir, ir_n, pc_id, pc_id_n;
  logic valid, valid_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      tgt <= '0;
      buf_ir <= '0;
      buf_pc <= '0;
      ir <= '0;
      pc_id <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      tgt <= tgt_n;
      buf_ir <= buf_ir_n;
      buf_pc <= buf_pc_n;
      ir <= ir_n;
      pc_id <= pc_id_n;
      valid <= valid_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    tgt_n = tgt;
    buf_ir_n = buf_ir;
    buf_pc_n = buf_pc;
    ir_n = ir;
    pc_id_n = pc_id;
    valid_n = valid;
    if (bus.i_redirect) begin
      ir_n = '0;
      valid_n = 1'b0;
      // an unacked request must complete before the target can be fetched
      if (state != HOLD && !bus.i_imem_ack) begin
        state_n = FLUSH;
        tgt_n = bus.i_redirect_pc;
      end else begin
        state_n = FETCH;
        pc_n = bus.i_redirect_pc;
      end
    end else if (state == FLUSH) begin
      if (bus.i_imem_ack) begin
        state_n = FETCH;
        pc_n = tgt;
      end
      if (!bus.i_stall) begin
        ir_n = '0;
        valid_n = 1'b0;
      end
    end else if (state == HOLD) begin
      if (!bus.i_stall) begin
        state_n = FETCH;
        ir_n = buf_ir;
        pc_id_n = buf_pc;
        valid_n = 1'b1;
      end
    end else if (bus.i_imem_ack) begin
      pc_n = pc + 16'd1;
      if (bus.i_stall) begin
        state_n = HOLD;
        buf_ir_n = bus.i_imem_rdata;
        buf_pc_n = pc;
      end else begin
        ir_n = bus.i_imem_rdata;
        pc_id_n = pc;
        valid_n = 1'b1;
      end
    end else if (!bus.i_stall) begin
      ir_n = '0;
      valid_n = 1'b0;
    end
  end
  assign bus.o_imem_req = !rst && state != HOLD;
  assign bus.o_imem_addr = pc;
  assign bus.o_ir_id = ir;
  assign bus.o_pc_id = pc_id;
  assign bus.o_ir_valid = valid;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (bus.i_stall && valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
  assign bus.o_stall_cnt = stall_cnt;
`endif
endmodule
